// File: rtl/saturn_bus_pkg.sv
// Shared definitions for the Saturn bus glue: nibble width, idle bus value,
// index-width helper and the bus command encodings used with the controller.
package saturn_bus_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] IDLE_NIBBLE_DEF = 4'hF;

  // Bus commands issued by saturn_bus_controller.
  typedef enum logic [2:0] {
    BUS_CMD_NOP    = 3'd0,
    BUS_CMD_CONFIG = 3'd1,
    BUS_CMD_RESET  = 3'd2,
    BUS_CMD_READ   = 3'd3,
    BUS_CMD_WRITE  = 3'd4
  } bus_cmd_e;

  // ceil(log2(n)), never below 1, so a single-channel index is still 1 bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/saturn_bus_arbiter_if.sv
// Bus bundle between the controller/slaves and the arbiter. The arbiter uses
// the slave modport; whoever drives the slaves and strobes uses master.
interface saturn_bus_arbiter_if
  import saturn_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4
);
  localparam int IDX_W = clog2_min1(NUM_SLAVES);

  logic                           i_bus_clk_en;
  logic                           i_bus_reset;
  logic                           i_config_strobe;
  logic [NUM_SLAVES-1:0]          i_slave_active;
  logic [NIBBLE_W*NUM_SLAVES-1:0] i_slave_nibble;
  logic [NIBBLE_W-1:0]            o_bus_nibble;
  logic                           o_sel_valid;
  logic [IDX_W-1:0]               o_sel_index;

  modport slave (
    input  i_bus_clk_en, i_bus_reset, i_config_strobe, i_slave_active, i_slave_nibble,
    output o_bus_nibble, o_sel_valid, o_sel_index
  );

  modport master (
    output i_bus_clk_en, i_bus_reset, i_config_strobe, i_slave_active, i_slave_nibble,
    input  o_bus_nibble, o_sel_valid, o_sel_index
  );

endinterface

// File: rtl/saturn_bus_prio_enc.sv
// Highest-set-bit encoder: reports whether any request is set, the index of
// the highest one, and whether more than one request is set.
module saturn_bus_prio_enc
  import saturn_bus_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] i_req,
  output logic             o_any,
  output logic [IDX_W-1:0] o_index,
  output logic             o_multi
);

  // Ascending scan so the last set bit seen (the highest) wins the index.
  always_comb begin
    o_any   = 1'b0;
    o_multi = 1'b0;
    o_index = '0;
    for (int k = 0; k < WIDTH; k++) begin
      o_multi = o_multi | (o_any & i_req[k]);
      o_index = i_req[k] ? IDX_W'(k) : o_index;
      o_any   = o_any | i_req[k];
    end
  end

endmodule

// File: rtl/saturn_bus_arbiter.sv
// Nibble arbiter between saturn_bus_controller and its bus slaves.
// Last-active-wins (highest index) priority, registered result, CONFIG/RESET
// daisy chain for the non-fixed slaves, and sticky collision reporting.
module saturn_bus_arbiter
  import saturn_bus_pkg::*;
#(
  parameter int                  NUM_SLAVES   = 4,
  parameter int                  FIXED_SLAVES = 1,
  parameter logic [NIBBLE_W-1:0] IDLE_NIBBLE  = IDLE_NIBBLE_DEF,
  parameter int                  ERR_CNT_W    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  saturn_bus_arbiter_if.slave   bus,
  input  logic                  i_clear_err,
  output logic [NUM_SLAVES-1:0] o_daisy_in,
  output logic [NUM_SLAVES-1:0] o_configured,
  output logic                  o_collision,
  output logic [ERR_CNT_W-1:0]  o_collision_cnt
);

  localparam int IDX_W   = clog2_min1(NUM_SLAVES);
  localparam int CFG_MAX = NUM_SLAVES - FIXED_SLAVES;
  localparam int CFG_W   = clog2_min1(CFG_MAX + 1);
  localparam logic [CFG_W-1:0]     CFG_MAX_V = CFG_W'(CFG_MAX);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};

  logic [CFG_W-1:0]      r_cfg_count;
  logic [NIBBLE_W-1:0]   r_bus_nibble;
  logic                  r_sel_valid;
  logic [IDX_W-1:0]      r_sel_index;
  logic                  r_collision;
  logic [ERR_CNT_W-1:0]  r_collision_cnt;

  logic [NUM_SLAVES-1:0] w_configured;
  logic [NUM_SLAVES-1:0] w_daisy_in;
  logic [NUM_SLAVES-1:0] w_qual;
  logic                  w_any;
  logic                  w_multi;
  logic                  w_collide;
  logic [IDX_W-1:0]      w_win_index;
  logic [NIBBLE_W-1:0]   w_win_nibble;

  // Decode the mapped set (thermometer) and the next CONFIG taker (one-hot).
  always_comb begin
    w_configured = '0;
    w_daisy_in   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      w_configured[k] = (k < FIXED_SLAVES + int'(r_cfg_count));
      w_daisy_in[k]   = (int'(r_cfg_count) < CFG_MAX) &&
                        (k == FIXED_SLAVES + int'(r_cfg_count));
    end
  end

  // Unmapped slaves are invisible to both arbitration and collision checks.
  assign w_qual = bus.i_slave_active & w_configured;

  saturn_bus_prio_enc #(
    .WIDTH (NUM_SLAVES),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_req   (w_qual),
    .o_any   (w_any),
    .o_index (w_win_index),
    .o_multi (w_multi)
  );

  // Pick the nibble of the highest qualified slave; idle value if none.
  always_comb begin
    w_win_nibble = IDLE_NIBBLE;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      w_win_nibble = w_qual[k] ? bus.i_slave_nibble[k*NIBBLE_W +: NIBBLE_W] : w_win_nibble;
    end
  end

  assign w_collide = bus.i_bus_clk_en & w_multi;

  // Capture the arbitration result on each bus nibble strobe.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_bus_nibble <= IDLE_NIBBLE;
      r_sel_valid  <= 1'b0;
      r_sel_index  <= '0;
    end else if (bus.i_bus_clk_en) begin
      r_bus_nibble <= w_win_nibble;
      r_sel_valid  <= w_any;
      r_sel_index  <= w_win_index;
    end else begin
      r_bus_nibble <= r_bus_nibble;
      r_sel_valid  <= r_sel_valid;
      r_sel_index  <= r_sel_index;
    end
  end

  // Daisy chain position: bus RESET clears it, CONFIG advances it to the end.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cfg_count <= '0;
    end else if (bus.i_bus_clk_en && bus.i_bus_reset) begin
      r_cfg_count <= '0;
    end else if (bus.i_bus_clk_en && bus.i_config_strobe && (r_cfg_count != CFG_MAX_V)) begin
      r_cfg_count <= r_cfg_count + CFG_W'(1);
    end else begin
      r_cfg_count <= r_cfg_count;
    end
  end

  // Sticky collision flag and saturating count; a same-cycle collision
  // survives a clear so it is never lost.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_collision     <= 1'b0;
      r_collision_cnt <= '0;
    end else if (i_clear_err) begin
      r_collision     <= w_collide;
      r_collision_cnt <= w_collide ? ERR_CNT_W'(1) : '0;
    end else if (w_collide) begin
      r_collision     <= 1'b1;
      r_collision_cnt <= (r_collision_cnt == CNT_MAX) ? r_collision_cnt
                                                       : r_collision_cnt + ERR_CNT_W'(1);
    end else begin
      r_collision     <= r_collision;
      r_collision_cnt <= r_collision_cnt;
    end
  end

  assign bus.o_bus_nibble = r_bus_nibble;
  assign bus.o_sel_valid  = r_sel_valid;
  assign bus.o_sel_index  = r_sel_index;
  assign o_daisy_in       = w_daisy_in;
  assign o_configured     = w_configured;
  assign o_collision      = r_collision;
  assign o_collision_cnt  = r_collision_cnt;

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// Self-checking bench for saturn_bus_arbiter. Two instances share stimulus:
// dut_a uses the defaults, dut_b uses a 2-bit error counter and idle value 0.
module tb_saturn_bus_arbiter;
  import saturn_bus_pkg::*;

  localparam int NS    = 4;
  localparam int FIXED = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, clk_en, bus_rst, cfg_strobe, clear_err;
  logic [NS-1:0]   act;
  logic [4*NS-1:0] nib;

  saturn_bus_arbiter_if #(.NUM_SLAVES(NS)) ifa ();
  saturn_bus_arbiter_if #(.NUM_SLAVES(NS)) ifb ();

  assign ifa.i_bus_clk_en    = clk_en;
  assign ifa.i_bus_reset     = bus_rst;
  assign ifa.i_config_strobe = cfg_strobe;
  assign ifa.i_slave_active  = act;
  assign ifa.i_slave_nibble  = nib;
  assign ifb.i_bus_clk_en    = clk_en;
  assign ifb.i_bus_reset     = bus_rst;
  assign ifb.i_config_strobe = cfg_strobe;
  assign ifb.i_slave_active  = act;
  assign ifb.i_slave_nibble  = nib;

  logic [NS-1:0] daisy_a, conf_a, daisy_b, conf_b;
  logic          coll_a, coll_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;

  saturn_bus_arbiter dut_a (
    .i_clk (clk), .i_reset (rst_n), .bus (ifa), .i_clear_err (clear_err),
    .o_daisy_in (daisy_a), .o_configured (conf_a),
    .o_collision (coll_a), .o_collision_cnt (cnt_a)
  );

  saturn_bus_arbiter #(.ERR_CNT_W(2), .IDLE_NIBBLE(4'h0)) dut_b (
    .i_clk (clk), .i_reset (rst_n), .bus (ifb), .i_clear_err (clear_err),
    .o_daisy_in (daisy_b), .o_configured (conf_b),
    .o_collision (coll_b), .o_collision_cnt (cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: how many daisy slaves are mapped, plus expected outputs.
  int       m_cfg   = 0;
  bit       m_coll  = 1'b0;
  int       m_cnt_a = 0;
  int       m_cnt_b = 0;
  bit [3:0] m_nib_a = 4'hF;
  bit [3:0] m_nib_b = 4'h0;
  bit       m_valid = 1'b0;
  int       m_idx   = 0;

  function automatic int exp_conf(input int cfg);
    return (1 << (FIXED + cfg)) - 1;
  endfunction

  function automatic int exp_daisy(input int cfg);
    return (cfg < NS - FIXED) ? (1 << (FIXED + cfg)) : 0;
  endfunction

  // Advance the model by one clock from the current inputs, then the clock.
  task automatic tick();
    int win;
    int nq;
    bit c;
    win = -1;
    nq  = 0;
    for (int k = 0; k < NS; k++) begin
      if (act[k] && (k < FIXED + m_cfg)) begin
        nq++;
        win = k;
      end
    end
    if (!rst_n) begin
      m_cfg = 0; m_coll = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
      m_nib_a = 4'hF; m_nib_b = 4'h0; m_valid = 1'b0; m_idx = 0;
    end else begin
      if (clk_en) begin
        if (win >= 0) begin
          m_nib_a = nib[4*win +: 4];
          m_nib_b = nib[4*win +: 4];
          m_valid = 1'b1;
          m_idx   = win;
        end else begin
          m_nib_a = 4'hF; m_nib_b = 4'h0; m_valid = 1'b0; m_idx = 0;
        end
        if (bus_rst) m_cfg = 0;
        else if (cfg_strobe && m_cfg < NS - FIXED) m_cfg++;
      end
      c = clk_en && (nq >= 2);
      if (clear_err) begin
        m_coll  = c;
        m_cnt_a = c ? 1 : 0;
        m_cnt_b = c ? 1 : 0;
      end else if (c) begin
        m_coll = 1'b1;
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3)   m_cnt_b++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; bus_rst = 1'b0; cfg_strobe = 1'b1; clear_err = 1'b0;
    act = 4'b1111; nib = 16'h3A5C;
    tick(); tick();
    n_checks++; if (ifa.o_bus_nibble !== 4'hF) begin n_fail++; $display("FAIL reset_nibble_a: got %h want %h", ifa.o_bus_nibble, 4'hF); end
    n_checks++; if (ifb.o_bus_nibble !== 4'h0) begin n_fail++; $display("FAIL reset_nibble_b: got %h want %h", ifb.o_bus_nibble, 4'h0); end
    n_checks++; if (ifa.o_sel_valid !== 1'b0 || ifa.o_sel_index !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got v=%b i=%0d want v=0 i=0", ifa.o_sel_valid, ifa.o_sel_index); end
    n_checks++; if (conf_a !== 4'b0001) begin n_fail++; $display("FAIL reset_configured: got %b want 0001", conf_a); end
    n_checks++; if (daisy_a !== 4'b0010) begin n_fail++; $display("FAIL reset_daisy: got %b want 0010", daisy_a); end
    n_checks++; if (coll_a !== 1'b0 || cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_collision: got %b/%0d want 0/0", coll_a, cnt_a); end
    rst_n = 1'b1; cfg_strobe = 1'b0; act = '0;
  endtask

  task automatic test_arbitration();
    act = 4'b0001; nib = 16'h0006; clk_en = 1'b1;
    tick();
    n_checks++; if (ifa.o_bus_nibble !== 4'h6 || ifa.o_sel_index !== 2'd0 || ifa.o_sel_valid !== 1'b1) begin
      n_fail++; $display("FAIL arb_rom: got n=%h i=%0d v=%b want n=6 i=0 v=1", ifa.o_bus_nibble, ifa.o_sel_index, ifa.o_sel_valid); end
    clk_en = 1'b0; nib = 16'h0009;
    tick(); tick();
    n_checks++; if (ifa.o_bus_nibble !== 4'h6) begin n_fail++; $display("FAIL arb_hold: got %h want 6", ifa.o_bus_nibble); end
    clk_en = 1'b1;
    tick();
    n_checks++; if (ifa.o_bus_nibble !== 4'h9) begin n_fail++; $display("FAIL arb_resume: got %h want 9", ifa.o_bus_nibble); end
    act = '0;
  endtask

  task automatic test_daisy();
    logic [NS-1:0] conf_tab  [4];
    logic [NS-1:0] daisy_tab [4];
    conf_tab  = '{4'b0011, 4'b0111, 4'b1111, 4'b1111};
    daisy_tab = '{4'b0100, 4'b1000, 4'b0000, 4'b0000};
    clk_en = 1'b1; act = '0;
    for (int i = 0; i < 4; i++) begin
      cfg_strobe = 1'b1;
      tick();
      n_checks++; if (conf_a !== conf_tab[i] || daisy_a !== daisy_tab[i]) begin
        n_fail++; $display("FAIL daisy_step%0d: got c=%b d=%b want c=%b d=%b", i, conf_a, daisy_a, conf_tab[i], daisy_tab[i]); end
    end
    bus_rst = 1'b1;
    tick();
    bus_rst = 1'b0;
    n_checks++; if (conf_a !== 4'b0001 || daisy_a !== 4'b0010) begin
      n_fail++; $display("FAIL daisy_busreset: got c=%b d=%b want c=0001 d=0010", conf_a, daisy_a); end
    clk_en = 1'b0;
    tick();
    n_checks++; if (conf_a !== 4'b0001) begin n_fail++; $display("FAIL daisy_noclken: got %b want 0001", conf_a); end
    clk_en = 1'b1;
    tick(); tick();
    rst_n = 1'b0; cfg_strobe = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (conf_a !== 4'b0001 || daisy_a !== 4'b0010) begin
      n_fail++; $display("FAIL daisy_midreset: got c=%b d=%b want c=0001 d=0010", conf_a, daisy_a); end
  endtask

  task automatic test_qualification();
    clk_en = 1'b1; act = 4'b1001; nib = 16'hA002;
    tick();
    n_checks++; if (ifa.o_bus_nibble !== 4'h2 || coll_a !== 1'b0 || cnt_a !== 8'd0) begin
      n_fail++; $display("FAIL qual_unmapped: got n=%h c=%b/%0d want n=2 c=0/0", ifa.o_bus_nibble, coll_a, cnt_a); end
    cfg_strobe = 1'b1;
    tick(); tick(); tick();
    cfg_strobe = 1'b0;
    tick();
    n_checks++; if (ifa.o_bus_nibble !== 4'hA || ifa.o_sel_index !== 2'd3) begin
      n_fail++; $display("FAIL qual_mapped: got n=%h i=%0d want n=A i=3", ifa.o_bus_nibble, ifa.o_sel_index); end
    n_checks++; if (coll_a !== 1'b1 || cnt_a !== 8'd1) begin
      n_fail++; $display("FAIL qual_collision: got %b/%0d want 1/1", coll_a, cnt_a); end
  endtask

  task automatic test_saturation_clear();
    act = '0; clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++; if (coll_a !== 1'b0 || cnt_a !== 8'd0) begin n_fail++; $display("FAIL clear_alone: got %b/%0d want 0/0", coll_a, cnt_a); end
    act = 4'b1001;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (coll_b !== 1'b1 || cnt_b !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_b: got %b/%0d want 1/3", coll_b, cnt_b); end
    n_checks++; if (cnt_a !== 8'd5) begin n_fail++; $display("FAIL sat_cnt_a: got %0d want 5", cnt_a); end
    clear_err = 1'b1;
    tick();
    n_checks++; if (coll_b !== 1'b1 || cnt_b !== 2'd1 || cnt_a !== 8'd1) begin
      n_fail++; $display("FAIL clear_with_coll: got %b/%0d/%0d want 1/1/1", coll_b, cnt_b, cnt_a); end
    clk_en = 1'b0;
    tick();
    n_checks++; if (coll_a !== 1'b0 || cnt_a !== 8'd0) begin n_fail++; $display("FAIL clear_no_clken: got %b/%0d want 0/0", coll_a, cnt_a); end
    clear_err = 1'b0; clk_en = 1'b1; act = '0;
  endtask

  task automatic test_idle();
    act = '0; clk_en = 1'b1; nib = 16'h5555;
    tick();
    n_checks++; if (ifa.o_bus_nibble !== 4'hF || ifa.o_sel_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_a: got n=%h v=%b want n=F v=0", ifa.o_bus_nibble, ifa.o_sel_valid); end
    n_checks++; if (ifb.o_bus_nibble !== 4'h0 || ifb.o_sel_valid !== 1'b0 || ifb.o_sel_index !== 2'd0) begin
      n_fail++; $display("FAIL idle_b: got n=%h v=%b i=%0d want n=0 v=0 i=0", ifb.o_bus_nibble, ifb.o_sel_valid, ifb.o_sel_index); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n      = ($urandom_range(0, 99) >= 2);
      clk_en     = ($urandom_range(0, 99) < 70);
      bus_rst    = ($urandom_range(0, 99) < 5);
      cfg_strobe = ($urandom_range(0, 99) < 20);
      clear_err  = ($urandom_range(0, 99) < 6);
      act        = NS'($urandom);
      nib        = 16'($urandom);
      tick();
      n_checks++; if (ifa.o_bus_nibble !== m_nib_a || ifb.o_bus_nibble !== m_nib_b) begin
        n_fail++; $display("FAIL rnd_nibble @%0d: got %h/%h want %h/%h", cyc, ifa.o_bus_nibble, ifb.o_bus_nibble, m_nib_a, m_nib_b); end
      n_checks++; if (ifa.o_sel_valid !== m_valid || ifa.o_sel_index !== 2'(m_idx)) begin
        n_fail++; $display("FAIL rnd_sel @%0d: got v=%b i=%0d want v=%b i=%0d", cyc, ifa.o_sel_valid, ifa.o_sel_index, m_valid, m_idx); end
      n_checks++; if (conf_a !== NS'(exp_conf(m_cfg)) || daisy_a !== NS'(exp_daisy(m_cfg)) || conf_b !== conf_a) begin
        n_fail++; $display("FAIL rnd_daisy @%0d: got c=%b d=%b want c=%b d=%b", cyc, conf_a, daisy_a, NS'(exp_conf(m_cfg)), NS'(exp_daisy(m_cfg))); end
      n_checks++; if (coll_a !== m_coll || cnt_a !== 8'(m_cnt_a)) begin
        n_fail++; $display("FAIL rnd_coll_a @%0d: got %b/%0d want %b/%0d", cyc, coll_a, cnt_a, m_coll, m_cnt_a); end
      n_checks++; if (coll_b !== m_coll || cnt_b !== 2'(m_cnt_b)) begin
        n_fail++; $display("FAIL rnd_coll_b @%0d: got %b/%0d want %b/%0d", cyc, coll_b, cnt_b, m_coll, m_cnt_b); end
    end
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; bus_rst = 1'b0; cfg_strobe = 1'b0; clear_err = 1'b0;
    act = '0; nib = '0;
    #1;
    test_reset();
    test_arbitration();
    test_daisy();
    test_qualification();
    test_saturation_clear();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/saturn_bus_arbiter.md
Name: saturn_bus_arbiter

Overview:
- Parametrised successor to the fixed single-ROM bus glue.
- Sits between saturn_bus_controller and N bus slaves (ROM, RAM, I/O, banked RAM); returns one nibble to the controller from the winning slave, using last-active-wins priority.
- Owns the Saturn configuration daisy chain (CONFIG/RESET), which decides which slave may claim the next CONFIG.
- Adds registered output, collision detection and an idle-bus value, none of which the fixed glue has.

Parameters:
- NUM_SLAVES, 4, number of slave channels; index 0 is lowest priority.
- FIXED_SLAVES, 1, slaves 0..FIXED_SLAVES-1 are always mapped and never take part in the daisy chain (ROM); range 0..NUM_SLAVES.
- IDLE_NIBBLE, 4'hF, value driven when no slave is active (pulled-up bus).
- ERR_CNT_W, 8, width of the collision counter.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-low reset.
- i_bus_clk_en  in  1  bus nibble strobe from controller; all bus state advances only when high.
- i_bus_reset  in  1  controller bus RESET command; unconfigures all daisy slaves.
- i_config_strobe  in  1  controller has finished sending a CONFIG address.
- i_slave_active  in  NUM_SLAVES  slave k is driving the bus this nibble.
- i_slave_nibble  in  4*NUM_SLAVES  slave k nibble at bits [4k+3:4k].
- i_clear_err  in  1  clears collision flag and counter.
- o_bus_nibble  out  4  registered nibble to controller i_bus_nibble_in.
- o_sel_valid  out  1  registered; a slave won the last sampled nibble.
- o_sel_index  out  clog2(NUM_SLAVES) (min 1)  registered winning index.
- o_daisy_in  out  NUM_SLAVES  one-hot; the slave that accepts the next CONFIG; all zero when the chain is exhausted.
- o_configured  out  NUM_SLAVES  thermometer; slave k is mapped.
- o_collision  out  1  sticky; two or more qualified slaves were active on one sampled nibble.
- o_collision_cnt  out  ERR_CNT_W  number of colliding nibbles, saturating.

Behaviour:
- Reset (i_reset=0 at a rising edge):
  - o_bus_nibble=IDLE_NIBBLE, o_sel_valid=0, o_sel_index=0.
  - cfg_count=0, so o_configured has only the fixed bits set.
  - o_collision=0, o_collision_cnt=0.
  - Reset wins over every other input in the same cycle.
- Qualified active: qual[k] = i_slave_active[k] & o_configured[k].
  - o_configured[k] = (k < FIXED_SLAVES) | (k-FIXED_SLAVES < cfg_count).
  - An unconfigured slave asserting active is ignored and does not count toward collision.
- Arbitration is combinational on qual; the winner is the highest index with qual set.
- Registering:
  - Only when i_bus_clk_en=1 do o_bus_nibble, o_sel_valid and o_sel_index register the winner's nibble and index.
  - If no slave qualifies: IDLE_NIBBLE, valid=0, index=0.
  - Latency is one clock from the sampled strobe cycle.
  - With i_bus_clk_en=0 all registered outputs hold.
- Daisy counter cfg_count:
  - Range 0..NUM_SLAVES-FIXED_SLAVES; updates only when i_bus_clk_en=1.
  - i_bus_reset=1 sets it to 0; this wins over i_config_strobe in the same cycle.
  - Otherwise i_config_strobe=1 increments it, saturating at the maximum; further strobes are no-ops.
  - o_daisy_in[FIXED_SLAVES+cfg_count]=1 while cfg_count < max, else all zero.
  - o_daisy_in and o_configured are decoded combinationally from the cfg_count register.
  - A configuration change affects qualification from the next cycle.
- Collision (evaluated on i_bus_clk_en=1 cycles):
  - popcount(qual) >= 2 sets o_collision and increments o_collision_cnt, saturating at all-ones.
  - Arbitration still delivers the highest index.
  - i_clear_err=1 clears both regardless of i_bus_clk_en.
  - Collision and clear in the same cycle: the flag ends 1 and the counter ends 1.
- Edge cases:
  - FIXED_SLAVES=NUM_SLAVES: no daisy chain; o_daisy_in stays 0.
  - NUM_SLAVES=1: o_sel_index is 1 bit wide and always 0.
  - Reset in the middle of a configuration sequence drops all daisy mappings.

Decomposition:
- Shared package saturn_bus_pkg:
  - NIBBLE_W=4;
  - the default IDLE_NIBBLE;
  - an index-width function clog2_min1;
  - the bus command encodings later shared with the controller.
- One natural sub-module, saturn_bus_prio_enc: parametrised highest-set-bit encoder producing any, index and a multi-hit flag.
- Daisy counter, output registers and error logic stay in the top module.

Test Plan:
- Reset: hold i_reset=0 for 2 clocks with slaves active -> o_bus_nibble=F, valid=0, o_configured=0001, o_daisy_in=0010, collision 0/0.
- Arbitration: ROM only active with nibble 6, strobe -> next clock o_bus_nibble=6, index 0.
  - Then set strobe=0 with nibble 9 -> outputs hold 6.
- Daisy: three strobes with config -> o_configured walks 0011, 0111, 1111 and o_daisy_in walks 0100, 1000, 0000.
  - A fourth strobe -> no change.
  - Bus reset together with a config strobe -> o_configured=0001.
- Qualification: slave 3 active with nibble A while unconfigured and ROM nibble 2 -> output 2, no collision.
  - After configuring all slaves -> output A, index 3, collision=1, cnt=1.
- Saturation and clear: ERR_CNT_W=2 with 5 colliding strobes -> cnt=3.
  - Clear concurrent with a collision -> flag=1, cnt=1.
  - Clear alone -> 0/0.
- Idle: no slave active with IDLE_NIBBLE=0 override -> o_bus_nibble=0, valid=0.
